// File: rtl/i2s_dac_tx_if.sv
// Sample-pair stream into the I2S DAC transmitter.
//
// Handshake: the source drives s_left/s_right/s_valid; the sink drives
// s_ready. A pair transfers on a rising clk edge where s_valid and s_ready
// are both 1. While s_valid is 1 and s_ready is 0 the source holds
// s_left/s_right stable. s_ready does not depend on s_valid.
interface i2s_dac_tx_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] s_left;
  logic [WIDTH-1:0] s_right;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output s_left,
    output s_right,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_left,
    input  s_right,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: serialises left/right PCM pairs onto bck/lrck/data.
// Bit clock is divided down from clk; a one-entry holding register feeds a
// per-frame load of the left/right sample registers. Mute and underrun act
// at frame granularity.
//
// Build option: define SNOS_DUAL_DATA_EN for dual-mono DAC mode, where
// i2s_dac_data carries the left sample in both slots and i2s_dac_data_r
// carries the right sample in both slots. Without it, i2s_dac_data carries
// interleaved L/R and i2s_dac_data_r stays 0.
module i2s_dac_tx #(
  parameter int WIDTH   = 24,
  parameter int SLOT    = 32,
  parameter int BCK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  i2s_dac_tx_if.slave   s,
  input  logic          mute,
  output logic          underrun,
  output logic          i2s_dac_bck,
  output logic          i2s_dac_lrck,
  output logic          i2s_dac_data,
  output logic          i2s_dac_data_r,
  output logic          dbg_hold_state
);

  localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT);

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  hold_state_t      hold_state;
  logic [WIDTH-1:0] hold_l;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] sh_l;
  logic [WIDTH-1:0] sh_r;
  logic [DW-1:0]    div;
  logic [BW-1:0]    b;

  logic             rise;
  logic             fall;
  logic             load_evt;
  logic             accept;
  logic [BW-1:0]    b_next;
  logic             lrck_next;
  logic             is_right;
  logic [BW-1:0]    slot_k;
  logic [WIDTH-1:0] load_l;
  logic [WIDTH-1:0] load_r;
  logic [WIDTH-1:0] cur_l;
  logic [WIDTH-1:0] cur_r;
  logic             l_bit;
  logic             r_bit;
  logic             data_next;
  logic             data_r_next;

  // Bit [WIDTH-1-k] of a sample, or 0 in the padding positions k >= WIDTH.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [BW-1:0]    k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k == BW'(WIDTH - 1 - i)) r = word[i];
    end
    return r;
  endfunction

  assign rise     = (div == DW'(BCK_DIV / 2 - 1));
  assign fall     = (div == DW'(BCK_DIV - 1));
  assign load_evt = fall && (b == '0);
  assign accept   = s.s_valid && (hold_state == HOLD_EMPTY);

  assign s.s_ready      = (hold_state == HOLD_EMPTY);
  assign dbg_hold_state = hold_state;

  // Next bit position, slot side and data bits for the upcoming fall strobe.
  // The bit emitted when b becomes b+1 is position p = b of the frame; at
  // b = 0 the left MSB goes out from the freshly loaded sample.
  always_comb begin
    b_next    = (b == BW'(2 * SLOT - 1)) ? '0 : b + 1'b1;
    lrck_next = (b_next >= BW'(SLOT));
    is_right  = (b >= BW'(SLOT));
    slot_k    = is_right ? b - BW'(SLOT) : b;
    load_l    = (hold_state == HOLD_FULL && !mute) ? hold_l : '0;
    load_r    = (hold_state == HOLD_FULL && !mute) ? hold_r : '0;
    cur_l     = (b == '0) ? load_l : sh_l;
    cur_r     = (b == '0) ? load_r : sh_r;
    l_bit     = pick_bit(cur_l, slot_k);
    r_bit     = pick_bit(cur_r, slot_k);
`ifdef SNOS_DUAL_DATA_EN
    data_next   = l_bit;
    data_r_next = r_bit;
`else
    data_next   = is_right ? r_bit : l_bit;
    data_r_next = 1'b0;
`endif
  end

  // Clock divider, serial outputs, frame load and the holding-register FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      div            <= '0;
      b              <= '0;
      i2s_dac_bck    <= 1'b0;
      i2s_dac_lrck   <= 1'b0;
      i2s_dac_data   <= 1'b0;
      i2s_dac_data_r <= 1'b0;
      underrun       <= 1'b0;
      sh_l           <= '0;
      sh_r           <= '0;
      hold_l         <= '0;
      hold_r         <= '0;
      hold_state     <= HOLD_EMPTY;
    end else begin
      underrun <= 1'b0;
      div      <= fall ? '0 : div + 1'b1;

      if (rise) i2s_dac_bck <= 1'b1;

      if (fall) begin
        i2s_dac_bck    <= 1'b0;
        b              <= b_next;
        i2s_dac_lrck   <= lrck_next;
        i2s_dac_data   <= data_next;
        i2s_dac_data_r <= data_r_next;
        if (load_evt) begin
          sh_l <= load_l;
          sh_r <= load_r;
          if (hold_state == HOLD_EMPTY) underrun <= 1'b1;
        end
      end

      // A full register is drained by the load; acceptance needs it empty,
      // so a load on a full register blocks acceptance for that cycle.
      case (hold_state)
        HOLD_FULL: begin
          if (load_evt) hold_state <= HOLD_EMPTY;
        end
        default: begin
          if (accept) begin
            hold_state <= HOLD_FULL;
            hold_l     <= s.s_left;
            hold_r     <= s.s_right;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

I2S transmitter that serialises parallel left/right PCM sample pairs onto the DAC serial port (`i2s_dac_bck`, `i2s_dac_lrck`, `i2s_dac_data`, `i2s_dac_data_r`). It is the output end of the SNOS audio path and mirrors the MCU-side I2S receiver. The serial clocks are derived from the system clock. Samples enter through a valid/ready handshake into a one-entry holding register. Mute and underrun are handled at frame granularity.

## Interface
- `WIDTH`, 24: sample width in bits; must satisfy 1 ≤ WIDTH ≤ SLOT.
- `SLOT`, 32: BCK periods per channel slot; one frame is 2*SLOT BCK periods.
- `BCK_DIV`, 4: `clk` cycles per BCK period; even, ≥ 2.
- `clk` in 1: system clock; everything is clocked on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_left` in WIDTH: left sample, two's complement.
- `s_right` in WIDTH: right sample, two's complement.
- `s_valid` in 1: sample pair valid.
- `s_ready` out 1: holding register empty.
- `mute` in 1: force zero output data.
- `underrun` out 1: one-cycle pulse when a frame starts with no sample available.
- `i2s_dac_bck` out 1: bit clock.
- `i2s_dac_lrck` out 1: word select; 0 = left, 1 = right.
- `i2s_dac_data` out 1: serial data, MSB first.
- `i2s_dac_data_r` out 1: second data line; see Configuration.

## Operation
- Divider counter `div` runs 0..BCK_DIV-1 and wraps.
  - Rise strobe at div = BCK_DIV/2-1: `bck` goes to 1.
  - Fall strobe at div = BCK_DIV-1: `bck` goes to 0.
- Bit counter `b` runs 0..2*SLOT-1. It advances (wrapping) on every fall strobe; all serial outputs update only on fall strobes.
- On the fall strobe where b becomes n:
  - `lrck` = (n ≥ SLOT).
  - Position p = (n-1) mod 2*SLOT.
  - Channel = right if p ≥ SLOT, else left.
  - k = p mod SLOT.
  - `data` = channel shift-register bit [WIDTH-1-k] if k < WIDTH, else 0.
- This is standard I2S: the MSB appears one BCK after the `lrck` edge, with zero padding after the LSB.
- Load event, on the fall strobe where b becomes 1:
  - If the holding register is full, copy `s_left`/`s_right` from it into the L/R shift registers (zeros instead if `mute` = 1 at that cycle), then empty the holding register.
  - If it is empty, load zeros and pulse `underrun` for that cycle.
- The right shift register is replaced only at load. The right LSB (when WIDTH = SLOT) is emitted at n = 0, before the reload.
- Handshake:
  - `s_ready` = holding register empty.
  - Transfer occurs when `s_valid` & `s_ready` at a rising `clk` edge.
  - The holding register becomes full on the next cycle.
  - `s_left`/`s_right` must be stable while `s_valid` is high and `s_ready` is low.
- Simultaneous load and `s_valid`: the load cycle sees a full register, so `s_ready` is 0 and no acceptance happens that cycle. The register empties on the next cycle and `s_ready` rises then.
- A muted sample is still consumed. `mute` does not stop the clocks.

## Timing
- Reset values:
  - `div` = 0, `b` = 0, holding register empty.
  - `bck`, `lrck`, `data`, `data_r` = 0.
  - `underrun` = 0; `s_ready` = 1.
- Reset asserted mid-frame takes effect on the next `clk` edge: outputs return to reset values and any held sample is discarded.
- After `rst` deasserts:
  - First `bck` rise at cycle BCK_DIV/2.
  - First fall and first load at cycle BCK_DIV; the left MSB is driven then.
- Latency:
  - A pair accepted before a load is output at that load; the left MSB is on `data` in the same cycle.
  - The maximum wait from acceptance to load is 2*SLOT*BCK_DIV cycles.
- Output data changes only at `bck` falling edges, so data is stable for BCK_DIV/2 cycles around each rising edge.
- Frame rate = f_clk / (2*SLOT*BCK_DIV).

## Configuration
- `SNOS_DUAL_DATA_EN` defined (dual-mono DAC mode):
  - `i2s_dac_data` carries the left sample in both slots.
  - `i2s_dac_data_r` carries the right sample in both slots, using the same bit positions (k) as `data`.
  - `lrck` is unchanged.
- Not defined: `i2s_dac_data_r` is constant 0 and `data` carries standard interleaved L/R.

## Test plan
- Reset: assert `rst` for 3 cycles mid-frame -> all serial outputs 0, `s_ready` = 1, `underrun` = 0; first `bck` rise at cycle BCK_DIV/2 after release.
- Single pair: L = 24'hABCDEF, R = 24'h123456, defaults -> `data` after the `lrck` fall is 101010111100110111101111 followed by 8 zeros; after the `lrck` rise it is 000100100011010001010110 followed by 8 zeros; `underrun` = 0.
- Underrun: no `s_valid` -> `underrun` pulses once per frame, exactly 256 cycles apart at defaults; `data` = 0 throughout.
- Backpressure: `s_valid` held high continuously -> exactly one acceptance per frame; `s_ready` low from acceptance until the cycle after the next load; no sample lost or duplicated across 4 frames of incrementing values.
- Mute: `mute` = 1 at load with L = 24'h7FFFFF -> sample consumed, `data` = 0 for the whole frame; `mute` = 0 on the next frame -> the next sample plays.
- `SNOS_DUAL_DATA_EN`: L = 24'h800000, R = 24'h000001 -> `data` is 1 at the MSB position of both slots; `data_r` is 1 at bit position k = 23 of both slots.
